// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle: state codes, motor speeds and
// default phase durations used by the sequencer, countdown and display.
package wash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FILL   = 4'd1,
        ST_WASH   = 4'd2,
        ST_DRAIN1 = 4'd3,
        ST_RINSE  = 4'd4,
        ST_DRAIN2 = 4'd5,
        ST_SPIN   = 4'd6,
        ST_DRY    = 4'd7,
        ST_DONE   = 4'd8,
        ST_PAUSE  = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        MOTOR_OFF  = 2'b00,
        MOTOR_SLOW = 2'b01,
        MOTOR_MED  = 2'b10,
        MOTOR_FAST = 2'b11
    } motor_t;

    localparam logic [3:0] T_FILL_DEF  = 4'd3;
    localparam logic [3:0] T_WASH_DEF  = 4'd9;
    localparam logic [3:0] T_DRAIN_DEF = 4'd2;
    localparam logic [3:0] T_RINSE_DEF = 4'd5;
    localparam logic [3:0] T_SPIN_DEF  = 4'd4;
    localparam logic [3:0] T_DRY_DEF   = 4'd9;

    // True for states that run against the countdown.
    function automatic logic is_timed(input state_t s);
        return s inside {ST_FILL, ST_WASH, ST_DRAIN1, ST_RINSE, ST_DRAIN2, ST_SPIN, ST_DRY};
    endfunction

endpackage

// File: rtl/wash_phase_ctrl_if.sv
// Signal bundle between the wash sequencer and its surroundings
// (countdown stage, buttons, actuators and LEDs).
interface wash_phase_ctrl_if;

    logic       cin;
    logic [3:0] count_in;
    logic       start;
    logic       door_open;
    logic       dry_en;
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic [3:0] phase;
    logic       valve;
    logic [1:0] motor;
    logic       pump;
    logic       heater;
    logic       done;

    modport master (
        output cin, count_in, start, door_open, dry_en,
        input  cnt_load, cnt_load_val, phase, valve, motor, pump, heater, done
    );

    modport slave (
        input  cin, count_in, start, door_open, dry_en,
        output cnt_load, cnt_load_val, phase, valve, motor, pump, heater, done
    );

endinterface

// File: rtl/wash_phase_ctrl_edge_det.sv
// Single-bit rising-edge detector; the previous-value register clears on reset.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic old;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (!rst_n) old <= 1'b0;
        else        old <= d;
    end

    assign rise = d & ~old;

endmodule

// File: rtl/wash_phase_ctrl.sv
// Wash/dry cycle sequencer: steps through the timed phases, reloads the
// countdown on every phase entry, handles door pause/resume and done.
module wash_phase_ctrl
    import wash_pkg::*;
#(
    parameter logic [3:0] T_FILL  = T_FILL_DEF,
    parameter logic [3:0] T_WASH  = T_WASH_DEF,
    parameter logic [3:0] T_DRAIN = T_DRAIN_DEF,
    parameter logic [3:0] T_RINSE = T_RINSE_DEF,
    parameter logic [3:0] T_SPIN  = T_SPIN_DEF,
    parameter logic [3:0] T_DRY   = T_DRY_DEF
) (
    input logic              CLK100MHZ,
    input logic              CPU_RESETN,
    wash_phase_ctrl_if.slave bus
);

    state_t     state, state_nx;
    state_t     saved, saved_nx;
    logic       dry_sel, dry_sel_nx;
    logic       armed;
    logic       tick_rise, start_rise, expire;
    logic       entry;
    logic [3:0] entry_val;
    logic       load_q;
    logic [3:0] load_val_q;
    logic       valve_q, pump_q, heater_q, done_q;
    motor_t     motor_q;

    edge_det u_tick_edge (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .d     (bus.cin),
        .rise  (tick_rise)
    );

    edge_det u_start_edge (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .d     (bus.start),
        .rise  (start_rise)
    );

    assign expire = armed & tick_rise & (bus.count_in == 4'd0);

    // Next-state, saved-state and dry-selection decisions.
    always_comb begin
        state_nx   = state;
        saved_nx   = saved;
        dry_sel_nx = dry_sel;
        case (state)
            ST_IDLE: begin
                if (start_rise && !bus.door_open) begin
                    dry_sel_nx = bus.dry_en;
                    state_nx   = ST_FILL;
                end
            end
            ST_FILL, ST_WASH, ST_DRAIN1, ST_RINSE, ST_DRAIN2, ST_SPIN, ST_DRY: begin
                // An open door outranks an expiry arriving on the same tick.
                if (bus.door_open) begin
                    saved_nx = state;
                    state_nx = ST_PAUSE;
                end else if (expire) begin
                    case (state)
                        ST_FILL:   state_nx = ST_WASH;
                        ST_WASH:   state_nx = ST_DRAIN1;
                        ST_DRAIN1: state_nx = ST_RINSE;
                        ST_RINSE:  state_nx = ST_DRAIN2;
                        ST_DRAIN2: state_nx = ST_SPIN;
                        ST_SPIN:   state_nx = dry_sel ? ST_DRY : ST_DONE;
                        default:   state_nx = ST_DONE;
                    endcase
                end
            end
            ST_PAUSE: begin
                if (start_rise && !bus.door_open) state_nx = saved;
            end
            ST_DONE: begin
                if (start_rise) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Any move into a timed state (including resume from pause) is an entry.
    always_comb begin
        entry     = is_timed(state_nx) && (state_nx != state);
        entry_val = '0;
        case (state_nx)
            ST_FILL:              entry_val = T_FILL;
            ST_WASH:              entry_val = T_WASH;
            ST_DRAIN1, ST_DRAIN2: entry_val = T_DRAIN;
            ST_RINSE:             entry_val = T_RINSE;
            ST_SPIN:              entry_val = T_SPIN;
            ST_DRY:               entry_val = T_DRY;
            default:              entry_val = '0;
        endcase
    end

    // State register, countdown reload pulse and arming of expiry.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state      <= ST_IDLE;
            saved      <= ST_IDLE;
            dry_sel    <= 1'b0;
            armed      <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            state      <= state_nx;
            saved      <= saved_nx;
            dry_sel    <= dry_sel_nx;
            load_q     <= entry;
            load_val_q <= entry ? entry_val : 4'd0;
            // Arm only once the reload pulse has gone, so a stale zero
            // from the previous phase cannot expire the new one.
            armed      <= entry ? 1'b0 : (armed | ~load_q);
        end
    end

    // Actuator and done decode, one cycle behind the state register.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            valve_q  <= 1'b0;
            motor_q  <= MOTOR_OFF;
            pump_q   <= 1'b0;
            heater_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valve_q  <= (state == ST_FILL) || (state == ST_RINSE);
            pump_q   <= (state == ST_DRAIN1) || (state == ST_DRAIN2) || (state == ST_SPIN);
            heater_q <= (state == ST_DRY);
            done_q   <= (state == ST_DONE);
            case (state)
                ST_WASH:           motor_q <= MOTOR_MED;
                ST_RINSE, ST_DRY:  motor_q <= MOTOR_SLOW;
                ST_SPIN:           motor_q <= MOTOR_FAST;
                default:           motor_q <= MOTOR_OFF;
            endcase
        end
    end

    assign bus.phase        = state;
    assign bus.cnt_load     = load_q;
    assign bus.cnt_load_val = load_val_q;
    assign bus.valve        = valve_q;
    assign bus.motor        = motor_q;
    assign bus.pump         = pump_q;
    assign bus.heater       = heater_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_wash_phase_ctrl.sv
// Bench for the wash sequencer: random tick spacing, a countdown model that
// feeds count_in, and a table-driven reference of the phase program.
module tb_wash_phase_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_auto = 1'b1;
    logic       auto_cin = 1'b0;
    logic       man_cin = 1'b0;
    logic       force0 = 1'b0;
    logic       start_r = 1'b0;
    logic       door_r = 1'b0;
    logic       dry_r = 1'b0;
    logic [3:0] cd;
    logic       cd_prev;
    int         errors = 0;
    int         checks = 0;

    wash_phase_ctrl_if bus ();

    assign bus.cin       = tick_auto ? auto_cin : man_cin;
    assign bus.count_in  = force0 ? 4'd0 : cd;
    assign bus.start     = start_r;
    assign bus.door_open = door_r;
    assign bus.dry_en    = dry_r;

    wash_phase_ctrl #(
        .T_FILL (4'd3),
        .T_WASH (4'd9),
        .T_DRAIN(4'd2),
        .T_RINSE(4'd5),
        .T_SPIN (4'd4),
        .T_DRY  (4'd9)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rstn),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Free-running 1 Hz stand-in: 2-cycle high pulses, random low gaps.
    initial begin
        forever begin
            repeat ($urandom_range(4, 9)) @(posedge clk);
            #1 auto_cin = 1'b1;
            repeat (2) @(posedge clk);
            #1 auto_cin = 1'b0;
        end
    end

    // Upstream countdown model: load wins, otherwise decrement on tick, hold at 0.
    always @(posedge clk) begin
        if (!rstn) begin
            cd      <= 4'd0;
            cd_prev <= 1'b0;
        end else begin
            cd_prev <= bus.cin;
            if (bus.cnt_load)                        cd <= bus.cnt_load_val;
            else if (bus.cin && !cd_prev && cd != 0) cd <= cd - 4'd1;
        end
    end

    function automatic int dur(input int p);
        case (p)
            1: return 3;
            2: return 9;
            3: return 2;
            4: return 5;
            5: return 2;
            6: return 4;
            7: return 9;
            default: return 0;
        endcase
    endfunction

    // {valve, motor[1:0], pump, heater} expected while in phase p
    function automatic logic [4:0] act_exp(input int p);
        case (p)
            1: return 5'b1_00_0_0;
            2: return 5'b0_10_0_0;
            3: return 5'b0_00_1_0;
            4: return 5'b1_01_0_0;
            5: return 5'b0_00_1_0;
            6: return 5'b0_11_1_0;
            7: return 5'b0_01_0_1;
            default: return 5'b0_00_0_0;
        endcase
    endfunction

    function automatic logic [4:0] act_now();
        return {bus.valve, bus.motor, bus.pump, bus.heater};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start_r = 1'b0; door_r = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic press_start();
        @(negedge clk) start_r = 1'b1;
        repeat (2) @(negedge clk);
        start_r = 1'b0;
    endtask

    task automatic press_and_catch(output bit got, output int ph, output int val);
        got = 0; ph = -1; val = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start_r = 1'b1;
            if (k == 3) start_r = 1'b0;
            if (bus.cnt_load && !got) begin
                got = 1; ph = int'(bus.phase); val = int'(bus.cnt_load_val);
            end
        end
    endtask

    task automatic wait_phase(input int p, input int limit, input string tag);
        int n = 0;
        while (int'(bus.phase) != p && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (int'(bus.phase) != p) begin
            errors++;
            $display("FAIL %s: phase=%0d required=%0d within %0d cycles", tag, bus.phase, p, limit);
        end
    endtask

    task automatic mtick();
        @(negedge clk) man_cin = 1'b1;
        @(negedge clk) man_cin = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Runs one program from IDLE to DONE and checks it against the phase table.
    task automatic run_full(input logic dry_start, input bit toggle, input string tag);
        int  exp_seq[$];
        int  got_ph[$];
        int  ld_ph[$];
        int  ld_val[$];
        int  ticks[16];
        int  cur = 0;
        int  n = 0;
        bit  lag = 0;
        bit  pc = 0;
        bit  toggled = 0;
        exp_seq = '{1, 2, 3, 4, 5, 6};
        if (dry_start) exp_seq.push_back(7);
        exp_seq.push_back(8);
        foreach (ticks[i]) ticks[i] = 0;
        dry_r = dry_start;
        while (auto_cin == 1'b0 && n < 50) begin @(negedge clk); n++; end
        while (auto_cin == 1'b1 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (int'(bus.phase) != 8 && n < 4000) begin
            @(negedge clk);
            if (n == 0) start_r = 1'b1;
            if (n == 2) start_r = 1'b0;
            if (bus.cnt_load) begin
                ld_ph.push_back(int'(bus.phase));
                ld_val.push_back(int'(bus.cnt_load_val));
            end
            if (int'(bus.phase) != cur) begin
                cur = int'(bus.phase);
                got_ph.push_back(cur);
                lag = 1;
            end else if (lag) begin
                lag = 0;
                checks++;
                if (act_now() !== act_exp(cur)) begin
                    errors++;
                    $display("FAIL %s act phase %0d: got=%b required=%b", tag, cur, act_now(), act_exp(cur));
                end
            end
            if (bus.cin && !pc) ticks[bus.phase]++;
            pc = bus.cin;
            if (toggle && !toggled && cur == 2) begin
                dry_r = ~dry_r;
                toggled = 1;
            end
            n++;
        end
        checks++;
        if (got_ph.size() != exp_seq.size()) begin
            errors++;
            $display("FAIL %s seq length: got=%0d required=%0d", tag, got_ph.size(), exp_seq.size());
        end else begin
            foreach (exp_seq[i]) begin
                checks++;
                if (got_ph[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL %s seq[%0d]: got=%0d required=%0d", tag, i, got_ph[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (ld_ph.size() != exp_seq.size() - 1) begin
            errors++;
            $display("FAIL %s load count: got=%0d required=%0d", tag, ld_ph.size(), exp_seq.size() - 1);
        end else begin
            foreach (ld_ph[i]) begin
                checks++;
                if (ld_ph[i] != exp_seq[i] || ld_val[i] != dur(exp_seq[i])) begin
                    errors++;
                    $display("FAIL %s load[%0d]: got phase %0d val %0d required phase %0d val %0d",
                             tag, i, ld_ph[i], ld_val[i], exp_seq[i], dur(exp_seq[i]));
                end
            end
        end
        for (int p = 1; p <= 7; p++) begin
            if (p == 7 && !dry_start) continue;
            checks++;
            if (ticks[p] != dur(p) + 1) begin
                errors++;
                $display("FAIL %s ticks phase %0d: got=%0d required=%0d", tag, p, ticks[p], dur(p) + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || act_now() !== 5'b0) begin
            errors++;
            $display("FAIL %s done: done=%b act=%b required done=1 act=00000", tag, bus.done, act_now());
        end
        press_start();
        @(negedge clk);
        checks++;
        if (bus.phase !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done->idle: phase=%0d done=%b required phase=0 done=0", tag, bus.phase, bus.done);
        end
    endtask

    task automatic test_reset();
        int loads = 0;
        do_reset();
        checks++;
        if ({bus.phase, bus.cnt_load, bus.cnt_load_val, act_now(), bus.done} !== 15'd0) begin
            errors++;
            $display("FAIL reset_initial: phase=%0d load=%b val=%0d act=%b done=%b required all 0",
                     bus.phase, bus.cnt_load, bus.cnt_load_val, act_now(), bus.done);
        end
        dry_r = 1'b0;
        press_start();
        wait_phase(2, 500, "reset_reach_wash");
        repeat ($urandom_range(3, 30)) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.phase, bus.cnt_load, bus.cnt_load_val, act_now(), bus.done} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_wash: phase=%0d load=%b val=%0d act=%b done=%b required all 0",
                     bus.phase, bus.cnt_load, bus.cnt_load_val, act_now(), bus.done);
        end
        rstn = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.cnt_load) loads++;
        end
        checks++;
        if (loads != 0 || bus.phase !== 4'd0) begin
            errors++;
            $display("FAIL reset_stray_ticks: loads=%0d phase=%0d required loads=0 phase=0", loads, bus.phase);
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        run_full(1'b0, bit'($urandom_range(0, 1)), "full_nodry");
    endtask

    task automatic test_dry();
        do_reset();
        run_full(1'b1, 1'b1, "full_dry");
    endtask

    task automatic test_door_pause();
        bit got;
        int ph, val;
        do_reset();
        dry_r = 1'($urandom_range(0, 1));
        press_start();
        wait_phase(4, 2000, "door_reach_rinse");
        repeat ($urandom_range(1, 6)) @(negedge clk);
        door_r = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.phase !== 4'd9) begin
            errors++;
            $display("FAIL door_pause: phase=%0d required=9", bus.phase);
        end
        @(negedge clk);
        checks++;
        if (act_now() !== 5'b0 || bus.cnt_load !== 1'b0) begin
            errors++;
            $display("FAIL door_pause_act: act=%b load=%b required act=00000 load=0", act_now(), bus.cnt_load);
        end
        press_and_catch(got, ph, val);
        checks++;
        if (got || bus.phase !== 4'd9) begin
            errors++;
            $display("FAIL door_open_start: load=%0d phase=%0d required load=0 phase=9", got, bus.phase);
        end
        door_r = 1'b0;
        repeat (2) @(negedge clk);
        press_and_catch(got, ph, val);
        checks++;
        if (!got || ph != 4 || val != 5) begin
            errors++;
            $display("FAIL door_resume: load=%0d phase=%0d val=%0d required load=1 phase=4 val=5", got, ph, val);
        end
        checks++;
        if (act_now() !== act_exp(4)) begin
            errors++;
            $display("FAIL door_resume_act: act=%b required=%b", act_now(), act_exp(4));
        end
    endtask

    task automatic test_stale_zero();
        do_reset();
        tick_auto = 1'b0; force0 = 1'b1; man_cin = 1'b0; dry_r = 1'b0;
        @(negedge clk) start_r = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.phase !== 4'd1 || bus.cnt_load !== 1'b1 || bus.cnt_load_val !== 4'd3) begin
            errors++;
            $display("FAIL stale_fill_entry: phase=%0d load=%b val=%0d required 1/1/3", bus.phase, bus.cnt_load, bus.cnt_load_val);
        end
        man_cin = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        checks++;
        if (bus.phase !== 4'd1 || bus.cnt_load !== 1'b0) begin
            errors++;
            $display("FAIL stale_tick_in_load: phase=%0d load=%b required phase=1 load=0", bus.phase, bus.cnt_load);
        end
        man_cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.phase !== 4'd1) begin
            errors++;
            $display("FAIL stale_hold: phase=%0d required=1", bus.phase);
        end
        man_cin = 1'b1;
        @(negedge clk);
        man_cin = 1'b0;
        checks++;
        if (bus.phase !== 4'd2 || bus.cnt_load !== 1'b1 || bus.cnt_load_val !== 4'd9) begin
            errors++;
            $display("FAIL stale_armed_expiry: phase=%0d load=%b val=%0d required 2/1/9", bus.phase, bus.cnt_load, bus.cnt_load_val);
        end
        tick_auto = 1'b1; force0 = 1'b0;
    endtask

    task automatic test_door_vs_expiry();
        bit got;
        int ph, val;
        do_reset();
        tick_auto = 1'b0; force0 = 1'b1; man_cin = 1'b0; dry_r = 1'b0;
        press_start();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 12 && int'(bus.phase) != 6; k++) mtick();
        checks++;
        if (bus.phase !== 4'd6) begin
            errors++;
            $display("FAIL dve_reach_spin: phase=%0d required=6", bus.phase);
        end
        @(negedge clk);
        man_cin = 1'b1; door_r = 1'b1;
        @(negedge clk);
        man_cin = 1'b0;
        checks++;
        if (bus.phase !== 4'd9) begin
            errors++;
            $display("FAIL door_beats_expiry: phase=%0d required=9", bus.phase);
        end
        door_r = 1'b0;
        repeat (2) @(negedge clk);
        press_and_catch(got, ph, val);
        checks++;
        if (!got || ph != 6 || val != 4) begin
            errors++;
            $display("FAIL dve_resume_spin: load=%0d phase=%0d val=%0d required load=1 phase=6 val=4", got, ph, val);
        end
        mtick();
        checks++;
        if (bus.phase !== 4'd8 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL dve_done: phase=%0d done=%b required phase=8 done=1", bus.phase, bus.done);
        end
        tick_auto = 1'b1; force0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_dry();
        test_door_pause();
        test_stale_zero();
        test_door_vs_expiry();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wash_phase_ctrl.md
Name: wash_phase_ctrl

Overview:
- Cycle sequencer that sits directly downstream of the per-phase countdown stage. It consumes that stage's 4-bit count and the same 1 Hz tick that drives it.
- Walks the washer/dryer through FILL, WASH, DRAIN, RINSE, SPIN and optional DRY.
- On each phase entry it reloads the countdown and drives the actuator outputs and status LEDs.
- Handles start, door-open pause/resume and done indication.

Parameters:
- T_FILL, 4'd3, FILL duration in ticks
- T_WASH, 4'd9, WASH duration in ticks
- T_DRAIN, 4'd2, DRAIN duration in ticks (used for both drain passes)
- T_RINSE, 4'd5, RINSE duration in ticks
- T_SPIN, 4'd4, SPIN duration in ticks
- T_DRY, 4'd9, DRY duration in ticks

Ports:
- CLK100MHZ  in  1  system clock, all logic on its rising edge
- CPU_RESETN  in  1  synchronous, active-low reset, sampled on the CLK100MHZ rising edge
- cin  in  1  1 Hz tick level, same signal that feeds the countdown; rising edge detected internally
- count_in  in  4  current countdown value from the countdown stage
- start  in  1  start/resume button, already debounced; rising edge detected internally
- door_open  in  1  level, 1 = door open
- dry_en  in  1  level, sampled only on start from IDLE; 1 = append DRY after SPIN
- cnt_load  out  1  one-cycle pulse that reloads the countdown
- cnt_load_val  out  4  reload value, valid while cnt_load=1
- phase  out  4  state encoding, for the 7-seg/LED display
- valve  out  1  water inlet
- motor  out  2  motor speed: 00 off, 01 slow, 10 medium, 11 fast
- pump  out  1  drain pump
- heater  out  1  dryer heater
- done  out  1  cycle-complete LED

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge, any state, mid-cycle included):
  - State goes to IDLE and the saved state clears.
  - All outputs go to 0: cnt_load=0, cnt_load_val=0, phase=0, valve=0, motor=00, pump=0, heater=0, done=0.
  - Edge-detect registers old_cin and old_start clear to 0.
- Edge detection:
  - tick_rise = old_cin==0 & cin==1.
  - start_rise = old_start==0 & start==1.
  - Both old_* registers update every cycle.
- State encodings: IDLE=0, FILL=1, WASH=2, DRAIN1=3, RINSE=4, DRAIN2=5, SPIN=6, DRY=7, DONE=8, PAUSE=9. All other codes are illegal and return to IDLE on the next edge.
- Phase entry, entering any timed state X:
  - In the same registered update, cnt_load=1 and cnt_load_val=T_X.
  - cnt_load drops to 0 on the next cycle.
  - An internal armed flag clears on entry and sets on the cycle after cnt_load deasserts. This blocks a stale count_in==0 from expiring the new phase.
- Phase expiry: in a timed state, expire when armed & tick_rise & count_in==0.
- Timed-state sequence: FILL -> WASH -> DRAIN1 -> RINSE -> DRAIN2 -> SPIN. From SPIN, go to DRY if dry_sel=1, else DONE. DRY -> DONE.
- Start:
  - IDLE: on start_rise & !door_open, latch dry_sel<=dry_en and enter FILL.
  - start_rise while door_open=1 in IDLE is ignored.
- Door:
  - door_open=1 in any timed state causes PAUSE on the next edge.
  - The interrupted state is held in a saved-state register. All actuators go to 0 and no cnt_load is issued.
  - Countdown stall is not this block's job. On resume the phase restarts from its full duration.
  - PAUSE -> saved state on start_rise & !door_open. This is a full phase entry with a fresh cnt_load.
- DONE:
  - done=1; all actuators 0.
  - On start_rise, go to IDLE, done=0.
  - door_open has no effect in DONE.
- Actuator map (registered; outputs change one cycle after the state change):
  - FILL: valve=1
  - WASH: motor=10
  - DRAIN1 and DRAIN2: pump=1
  - RINSE: valve=1, motor=01
  - SPIN: motor=11, pump=1
  - DRY: motor=01, heater=1
  - All other states: all actuators 0.
- Simultaneous events:
  - door_open beats expiry on the same cycle, so the block pauses without advancing.
  - Reset beats everything.
- A T_X=0 parameter expires on the first armed tick.
- phase output mirrors the state register.

Decomposition:
- Shared package/header wash_pkg holds:
  - the state encodings, 4-bit;
  - the motor speed codes;
  - default duration constants. The countdown stage and the display decoder use these too.
- One sub-module, edge_det: 1-bit rising-edge detector with sync active-low reset, instantiated for cin and start.
- The FSM, duration mux and actuator decode stay in wash_phase_ctrl.

Test Plan:
1. Reset mid-WASH: CPU_RESETN=0 for 1 cycle -> next edge shows phase=0 and all outputs 0. Stray ticks afterwards cause no cnt_load.
2. Full cycle, dry_en=0, count_in driven by a model countdown -> phase goes 1,2,3,4,5,6,8. Exactly one cnt_load per entry, with values 3,9,2,5,2,4. Then done=1.
3. dry_en=1 at start, toggled to 0 mid-cycle -> DRY (phase=7) is still entered after SPIN, with cnt_load_val=9, heater=1, motor=01.
4. door_open=1 during RINSE -> PAUSE (9) with actuators 0. start_rise while the door is open is ignored. After door close plus start_rise -> RINSE re-entered with cnt_load_val=5.
5. Stale zero: count_in held at 0 when FILL is entered, tick arriving in the cnt_load cycle -> no expiry until armed. A later tick with count_in=0 then advances to WASH.
6. door_open=1 on the same cycle as an expiry tick in SPIN -> PAUSE, saved state = SPIN. No DONE.
